df_seg_display: RTL and testbench
=================================

Name: df_seg_display

Overview:
- Downstream output stage for df_digital_filter.
- Captures the filter's 8-bit dataout on a load strobe and converts it to three BCD digits with a sequential double-dabble engine (or splits it into hex nibbles).
- Drives a time-multiplexed 3-digit 7-segment display.
- Sits between the filter and the uo_out/uio_out pins of the top level.

Parameters:
- REFRESH_DIV, 1024: CLK cycles each digit stays enabled; legal range >=2.
- SEG_ACTIVE_LOW, 0: 1 inverts seg outputs, for common-anode displays.
- DIG_ACTIVE_LOW, 0: 1 inverts dig_en outputs.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- datain  in  8  filtered sample from df_digital_filter.
- load  in  1  capture request; sampled only while idle.
- hexmode  in  1  0 = unsigned decimal 0..255, 1 = hex 00..FF; captured with datain.
- busy  out  1  high while a conversion or update is in progress; registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW.
- dig_en  out  3  one-hot digit enable; bit0 = ones (rightmost), registered, polarity per DIG_ACTIVE_LOW.

Behaviour:
- Polarity: all patterns below are active-high logical values; the parameter inversion is applied at the output register.
- FSM states: IDLE, CONV, UPD.
- IDLE:
  - load=1 at edge N: capture datain into the shift register and hexmode into mode_q; clear the BCD register; go to CONV.
  - busy=1 from N+1.
- CONV: runs 8 cycles (iteration counter 0..7, 3 bits). Each cycle:
  - add 3 to every BCD nibble >=5;
  - shift {bcd[11:0], sh[7:0]} left by 1.
  - After iteration 7, go to UPD.
- UPD: one cycle; write the display registers; go to IDLE. busy=0 from the edge leaving UPD.
- Timing for load sampled at edge N:
  - busy high during cycles N+1..N+9;
  - display registers hold the new value from edge N+9;
  - the new segment pattern appears at most one CLK later than the digit's next scan slot.
- Display registers:
  - Decimal mode: d2/d1/d0 = hundreds/tens/ones.
  - Hex mode: d2 = blank, d1 = datain[7:4], d0 = datain[3:0]. CONV still runs its full 8 cycles so latency is mode-independent.
- Leading-zero blanking, decimal only:
  - d2 blank when hundreds=0;
  - d1 blank when hundreds=0 and tens=0;
  - d0 never blank, so value 0 shows "0".
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 (width $clog2(REFRESH_DIV)).
  - On wrap, digit index advances 0->1->2->0.
  - Index 3 is unreachable; if ever reached, next value is 0.
- Output register:
  - every cycle, dig_en <= onehot(index) and seg <= decode(digit[index]) or 0 if blank;
  - seg and dig_en change on the same edge (no cross-digit ghosting).
- Decode table (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Load handling: load while busy is ignored (no queueing). Continuous load produces a new capture every 10 cycles.
- RST (synchronous, any state, including mid-CONV):
  - FSM to IDLE; busy=0;
  - shift, BCD and display registers =0; refresh counter=0; index=0;
  - seg=0 and dig_en=0 (logical).
  - First edge after RST deasserts: dig_en=001, seg=0111111 ("0").
- datain and hexmode are assumed already synchronised by the top level; no internal synchronisers.

Test Plan:
- Reset: RST=1 for 2 cycles -> busy=0, seg=0000000, dig_en=000. Release -> next edge dig_en=001, seg=0111111.
- Decimal: REFRESH_DIV=4, load=1 with datain=237 at edge N -> busy high for N+1..N+9. After update, scan shows dig_en=001 with seg=0000111, 010 with 1001111, 100 with 1011011.
- Blanking: datain=5 decimal -> digits 2 and 1 seg=0000000, digit 0 seg=1101101. datain=40 -> digit2 blank, digit1 1100110, digit0 0111111.
- Hex: hexmode=1, datain=8'hA7 -> digit2 blank, digit1 1110111, digit0 0000111. Latency identical to decimal (busy 9 cycles).
- Busy/overlap: load pulsed at N and N+4 -> second pulse ignored, exactly one conversion. load held high -> captures at N, N+10, N+20. datain=255 -> 2/5/5.
- Mid-conversion reset: RST at N+4 -> next edge busy=0, display shows "0" on digit 0. Refresh with REFRESH_DIV=4 -> dig_en steps 001->010->100->001 every 4 cycles. Check both polarity parameters set to 1 invert seg and dig_en.

Source files
------------

// File: rtl/df_seg_display.sv
// ----------------------------------------------------------------------------
// df_seg_display
//
// Output stage for the digital filter. A load strobe captures an 8-bit sample.
// A sequential double-dabble engine turns it into three BCD digits, or the
// sample is split into two hex nibbles. The result drives a time-multiplexed
// 3-digit 7-segment display.
//
// Parameters:
//   REFRESH_DIV    - clock cycles each digit stays enabled (>= 2)
//   SEG_ACTIVE_LOW - 1 inverts seg (common-anode displays)
//   DIG_ACTIVE_LOW - 1 inverts dig_en
//
// Ports:
//   CLK     in   1  clock, rising edge
//   RST     in   1  synchronous active-high reset
//   datain  in   8  filtered sample
//   load    in   1  capture request, honoured only while idle
//   hexmode in   1  0 = unsigned decimal, 1 = hex; captured with datain
//   busy    out  1  conversion/update in progress (registered)
//   seg     out  7  segments {g,f,e,d,c,b,a} (registered)
//   dig_en  out  3  one-hot digit enable, bit0 = ones digit (registered)
// ----------------------------------------------------------------------------
module df_seg_display #(
    parameter int REFRESH_DIV    = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] datain,
    input  logic       load,
    input  logic       hexmode,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] dig_en
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    iter_q, iter_d;
    logic [7:0]    sh_q, sh_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [7:0]    raw_q, raw_d;
    logic          mode_q, mode_d;
    logic [3:0]    d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic          blank2_q, blank2_d, blank1_q, blank1_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    dig_q, dig_d;

    logic [11:0]   adj;
    logic [19:0]   shifted;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b0111111;
            4'h1:    p = 7'b0000110;
            4'h2:    p = 7'b1011011;
            4'h3:    p = 7'b1001111;
            4'h4:    p = 7'b1100110;
            4'h5:    p = 7'b1101101;
            4'h6:    p = 7'b1111101;
            4'h7:    p = 7'b0000111;
            4'h8:    p = 7'b1111111;
            4'h9:    p = 7'b1101111;
            4'hA:    p = 7'b1110111;
            4'hB:    p = 7'b1111100;
            4'hC:    p = 7'b0111001;
            4'hD:    p = 7'b1011110;
            4'hE:    p = 7'b1111001;
            default: p = 7'b1110001;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM: next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        sh_d     = sh_q;
        bcd_d    = bcd_q;
        raw_d    = raw_q;
        mode_d   = mode_q;
        d2_d     = d2_q;
        d1_d     = d1_q;
        d0_d     = d0_q;
        blank2_d = blank2_q;
        blank1_d = blank1_q;
        adj      = dabble_adj(bcd_q);
        shifted  = {adj, sh_q} << 1;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sh_d    = datain;
                    raw_d   = datain;
                    mode_d  = hexmode;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // The conversion runs in hex mode too, so latency does not
                // depend on the display mode.
                bcd_d  = shifted[19:8];
                sh_d   = shifted[7:0];
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                if (mode_q) begin
                    d2_d     = 4'd0;
                    d1_d     = raw_q[7:4];
                    d0_d     = raw_q[3:0];
                    blank2_d = 1'b1;
                    blank1_d = 1'b0;
                end else begin
                    d2_d     = bcd_q[11:8];
                    d1_d     = bcd_q[7:4];
                    d0_d     = bcd_q[3:0];
                    // Leading-zero blanking; the ones digit is always lit.
                    blank2_d = (bcd_q[11:8] == 4'd0);
                    blank1_d = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Refresh scan and output register next values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;
            endcase
        end

        cur_digit = 4'd0;
        cur_blank = 1'b1;
        dig_d     = 3'b000;
        case (idx_q)
            2'd0: begin
                cur_digit = d0_q;
                cur_blank = 1'b0;
                dig_d     = 3'b001;
            end
            2'd1: begin
                cur_digit = d1_q;
                cur_blank = blank1_q;
                dig_d     = 3'b010;
            end
            2'd2: begin
                cur_digit = d2_q;
                cur_blank = blank2_q;
                dig_d     = 3'b100;
            end
            default: begin
                cur_digit = 4'd0;
                cur_blank = 1'b1;
                dig_d     = 3'b000;
            end
        endcase

        seg_d = cur_blank ? 7'b0000000 : decode(cur_digit);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            iter_q   <= '0;
            sh_q     <= '0;
            bcd_q    <= '0;
            raw_q    <= '0;
            mode_q   <= 1'b0;
            d2_q     <= '0;
            d1_q     <= '0;
            d0_q     <= '0;
            blank2_q <= 1'b1;
            blank1_q <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= {7{SEG_ACTIVE_LOW}};
            dig_q    <= {3{DIG_ACTIVE_LOW}};
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            raw_q    <= raw_d;
            mode_q   <= mode_d;
            d2_q     <= d2_d;
            d1_q     <= d1_d;
            d0_q     <= d0_d;
            blank2_q <= blank2_d;
            blank1_q <= blank1_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            // seg and dig_en update together so no digit shows its
            // neighbour's pattern.
            seg_q    <= seg_d ^ {7{SEG_ACTIVE_LOW}};
            dig_q    <= dig_d ^ {3{DIG_ACTIVE_LOW}};
        end
    end

    assign busy   = busy_q;
    assign seg    = seg_q;
    assign dig_en = dig_q;

endmodule

// File: tb/tb_df_seg_display.sv
module tb_df_seg_display;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] datain;
    logic       load;
    logic       hexmode;
    logic       busy,   busy_n;
    logic [6:0] seg,    seg_n;
    logic [2:0] dig_en, dig_en_n;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    df_seg_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b0),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .datain (datain),
        .load   (load),
        .hexmode(hexmode),
        .busy   (busy),
        .seg    (seg),
        .dig_en (dig_en)
    );

    df_seg_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut_n (
        .CLK    (CLK),
        .RST    (RST),
        .datain (datain),
        .load   (load),
        .hexmode(hexmode),
        .busy   (busy_n),
        .seg    (seg_n),
        .dig_en (dig_en_n)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load a value, check busy over the 9-cycle window, leave at the UPD edge.
    task automatic do_load(input string tag, input logic [7:0] v, input logic hx);
        datain  = v;
        hexmode = hx;
        load    = 1'b1;
        tick(1);
        chk({tag, "_busy_n0"}, busy, 1);
        load = 1'b0;
        tick(8);
        chk({tag, "_busy_n8"}, busy, 1);
        tick(1);
        chk({tag, "_busy_n9"}, busy, 0);
    endtask

    // Watch a full scan and check every slot against the expected digits.
    task automatic scan(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                        input logic [6:0] e0);
        logic [2:0] seen;
        logic [6:0] inv;
        seen = 3'b000;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            case (dig_en)
                3'b001: begin
                    chk({tag, "_dig0"}, seg, e0);
                    inv = ~e0;
                    chk({tag, "_dig0_inv"}, seg_n, inv);
                    seen[0] = 1'b1;
                end
                3'b010: begin
                    chk({tag, "_dig1"}, seg, e1);
                    seen[1] = 1'b1;
                end
                3'b100: begin
                    chk({tag, "_dig2"}, seg, e2);
                    seen[2] = 1'b1;
                end
                default: chk({tag, "_onehot"}, dig_en, 3'b001);
            endcase
            tick(1);
        end
        chk({tag, "_seen"}, seen, 3'b111);
    endtask

    initial begin
        logic [2:0] exp_dig;
        logic [2:0] exp_dig_n;
        RST     = 1'b1;
        load    = 1'b0;
        datain  = 8'd0;
        hexmode = 1'b0;

        // Reset state
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_seg", seg, 7'b0000000);
        chk("rst_dig", dig_en, 3'b000);
        chk("rst_seg_inv", seg_n, 7'b1111111);
        chk("rst_dig_inv", dig_en_n, 3'b111);
        RST = 1'b0;
        tick(1);
        chk("rel_dig", dig_en, 3'b001);
        chk("rel_seg", seg, 7'b0111111);
        chk("rel_dig_inv", dig_en_n, 3'b110);
        chk("rel_seg_inv", seg_n, 7'b1000000);

        // Decimal 237
        do_load("d237", 8'd237, 1'b0);
        scan("d237", 7'b1011011, 7'b1001111, 7'b0000111);

        // Blanking
        do_load("d5", 8'd5, 1'b0);
        scan("d5", 7'b0000000, 7'b0000000, 7'b1101101);
        do_load("d40", 8'd40, 1'b0);
        scan("d40", 7'b0000000, 7'b1100110, 7'b0111111);

        // Hex A7
        do_load("hA7", 8'hA7, 1'b1);
        scan("hA7", 7'b0000000, 7'b1110111, 7'b0000111);

        // Overlapping load: second pulse at N+4 ignored
        datain  = 8'd255;
        hexmode = 1'b0;
        load    = 1'b1;
        tick(1);
        chk("ovl_busy_n0", busy, 1);
        load   = 1'b0;
        datain = 8'd99;
        tick(3);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("ovl_busy_n4", busy, 1);
        tick(4);
        chk("ovl_busy_n8", busy, 1);
        tick(1);
        chk("ovl_busy_n9", busy, 0);
        tick(1);
        chk("ovl_busy_n10", busy, 0);
        scan("d255", 7'b1011011, 7'b1101101, 7'b1101101);

        // Continuous load: captures at N, N+10, N+20
        datain = 8'd237;
        load   = 1'b1;
        tick(1);
        chk("cont_busy_n0", busy, 1);
        datain = 8'd5;
        tick(9);
        chk("cont_busy_n9", busy, 0);
        tick(1);
        chk("cont_busy_n10", busy, 1);
        datain = 8'd40;
        tick(9);
        chk("cont_busy_n19", busy, 0);
        tick(1);
        chk("cont_busy_n20", busy, 1);
        load = 1'b0;
        tick(9);
        chk("cont_busy_n29", busy, 0);
        scan("cont40", 7'b0000000, 7'b1100110, 7'b0111111);

        // Reset in the middle of a conversion
        datain = 8'd237;
        load   = 1'b1;
        tick(1);
        load = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(1);
        chk("mid_busy", busy, 0);
        chk("mid_seg", seg, 7'b0000000);
        chk("mid_dig", dig_en, 3'b000);
        chk("mid_seg_inv", seg_n, 7'b1111111);
        RST = 1'b0;
        tick(1);
        chk("mid_rel_dig", dig_en, 3'b001);
        chk("mid_rel_seg", seg, 7'b0111111);

        // Refresh cadence with REFRESH_DIV=4, both polarities
        for (int k = 2; k <= 13; k++) begin
            tick(1);
            if (k <= 4)       exp_dig = 3'b001;
            else if (k <= 8)  exp_dig = 3'b010;
            else if (k <= 12) exp_dig = 3'b100;
            else              exp_dig = 3'b001;
            exp_dig_n = ~exp_dig;
            chk($sformatf("ref_dig_%0d", k), dig_en, exp_dig);
            chk($sformatf("ref_dig_inv_%0d", k), dig_en_n, exp_dig_n);
            chk($sformatf("ref_busy_%0d", k), busy, 0);
            if (exp_dig == 3'b001) begin
                chk($sformatf("ref_seg_%0d", k), seg, 7'b0111111);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
